// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
// Optional build macro: PS2_PARITY_CHECK_EN (see ps2_frame_rx).
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    localparam int FILTER_LEN_DEFAULT     = 8;
    localparam int TIMEOUT_CYCLES_DEFAULT = 50000;

    // True when the data byte plus its parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 clock, debounces it over FILTER_LEN samples and
// flags the cycle in which the filtered clock falls.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_raw,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync_q, sync_d;
    logic             filt_q, filt_d;
    logic             filt_prev_q, filt_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter tracks how long the synchronized level has disagreed with
    // the filtered level; any agreeing sample restarts the count.
    always_comb begin
        sync_d      = {sync_q[0], ps2_clk_raw};
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        cnt_d       = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            sync_q      <= sync_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fall = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: start, 8 data bits LSB-first, odd parity, stop.
// Macro PS2_PARITY_CHECK_EN enables dropping frames with bad parity.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = FILTER_LEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PS2Clk,
    input  logic        PS2Data,
    output logic [15:0] keycode,
    output logic        oflag,
    output logic        parity_err,
    output logic        frame_err
);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic       fall;
    logic [1:0] data_sync_q;
    logic       data_s;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_raw (PS2Clk),
        .fall        (fall)
    );

    // Data only needs synchronizing; it is sampled long after it settles.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync_q <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], PS2Data};
        end
    end

    assign data_s = data_sync_q[1];

    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [15:0]      keycode_q, keycode_d;
    logic             oflag_q, oflag_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        tmo_d        = tmo_q;
        keycode_d    = keycode_q;
        oflag_d      = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        // An edge always wins over a timeout in the same cycle.
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_ok_d = odd_parity_ok(shift_q, data_s);
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else if (PARITY_EN && !par_ok_q) begin
                        parity_err_d = 1'b1;
                    end else begin
                        keycode_d = {keycode_q[7:0], shift_q};
                        oflag_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
            state_d     = IDLE;
            shift_d     = '0;
            bit_cnt_d   = '0;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            tmo_q        <= '0;
            keycode_q    <= '0;
            oflag_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            tmo_q        <= tmo_d;
            keycode_q    <= keycode_d;
            oflag_q      <= oflag_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign keycode    = keycode_q;
    assign oflag      = oflag_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule
